ps2_keycode_rx: RTL and testbench

PS/2 keyboard front end. It samples the raw `ps2c`/`ps2d` lines, deframes 11-bit device-to-host frames, and checks parity and the stop bit. It extracts one scan code per keystroke, taken from the release sequence `F0 xx`, and buffers those codes in a small FIFO. Downstream consumers are the key-to-ASCII converter and the UART transmit path; they pop codes through a first-word-fall-through read handshake.

---
 rtl/ps2_keycode_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_keycode_rx
//  Brief    : PS/2 keyboard receiver; keeps the code following each F0 break
//             prefix and queues it in a first-word-fall-through FIFO.
//  Revision : 1.0
// ============================================================================
module ps2_keycode_rx #(
    parameter int unsigned W_SIZE      = 2,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rd_key_code,
    output logic [7:0] key_code,
    output logic       kb_buf_empty,
    output logic       kb_buf_full,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned c_DEPTH = 1 << W_SIZE;
    localparam int unsigned c_TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DPS  = 2'd1,
        S_LOAD = 2'd2
    } frame_state_t;

    typedef enum logic [0:0] {
        S_WAIT_BRK = 1'b0,
        S_GET_CODE = 1'b1
    } code_state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic                  r_fall;
    logic [FILTER_LEN-1:0] w_filt_next;
    logic                  w_d;

    assign w_filt_next = {r_filt[FILTER_LEN-2:0], r_c_sync[1]};
    assign w_d         = r_d_sync[1];

    // Idle PS/2 lines are high, so the conditioning chain resets to ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_filt   <= '1;
            r_fclk   <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c};
            r_d_sync <= {r_d_sync[0], ps2d};
            r_filt   <= w_filt_next;
            if (&w_filt_next) begin
                r_fclk <= 1'b1;
            end else if (~|w_filt_next) begin
                r_fclk <= 1'b0;
            end
            r_fall <= r_fclk & ~|w_filt_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_t    r_fstate;
    logic [10:0]     r_b;
    logic [3:0]      r_n;
    logic [c_TW-1:0] r_tcnt;
    logic            r_frame_err;
    logic            w_frame_ok;
    logic            w_rx_valid;
    logic [7:0]      w_rx_byte;

    assign w_frame_ok = r_b[10] & (^r_b[9:1]) & ~r_b[0];
    assign w_rx_valid = (r_fstate == S_LOAD) & w_frame_ok;
    assign w_rx_byte  = r_b[8:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fstate    <= S_IDLE;
            r_b         <= '0;
            r_n         <= '0;
            r_tcnt      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_fstate)
                S_IDLE: begin
                    if (r_fall && !w_d) begin
                        r_b      <= {w_d, r_b[10:1]};
                        r_n      <= 4'd9;
                        r_tcnt   <= '0;
                        r_fstate <= S_DPS;
                    end
                end
                S_DPS: begin
                    if (r_fall) begin
                        r_b    <= {w_d, r_b[10:1]};
                        r_tcnt <= '0;
                        if (r_n == 4'd0) begin
                            r_fstate <= S_LOAD;
                        end else begin
                            r_n <= r_n - 4'd1;
                        end
                    end else if (r_tcnt == c_TMO_LAST) begin
                        r_fstate    <= S_IDLE;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_fstate <= S_IDLE;
                    if (!w_frame_ok) begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_fstate <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Code FSM: only the byte after a break prefix is kept; E0 inside a
    // break sequence is an extended-key marker and is skipped.
    // ------------------------------------------------------------------
    code_state_t r_cstate;
    logic        w_push;

    assign w_push = w_rx_valid && (r_cstate == S_GET_CODE) &&
                    (w_rx_byte != 8'hF0) && (w_rx_byte != 8'hE0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cstate <= S_WAIT_BRK;
        end else if (w_rx_valid) begin
            case (r_cstate)
                S_WAIT_BRK: begin
                    if (w_rx_byte == 8'hF0) begin
                        r_cstate <= S_GET_CODE;
                    end
                end
                S_GET_CODE: begin
                    if (w_rx_byte != 8'hF0 && w_rx_byte != 8'hE0) begin
                        r_cstate <= S_WAIT_BRK;
                    end
                end
                default: r_cstate <= S_WAIT_BRK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]        r_mem [0:c_DEPTH-1];
    logic [W_SIZE-1:0] r_wr_ptr;
    logic [W_SIZE-1:0] r_rd_ptr;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic [W_SIZE-1:0] w_wr_next;
    logic [W_SIZE-1:0] w_rd_next;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_wr_next = r_wr_ptr + 1'b1;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_rd_en   = rd_key_code & ~r_empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_wr_en   = w_push & (~r_full | w_rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(c_DEPTH); i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & r_full & ~w_rd_en;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_rx_byte;
                r_wr_ptr        <= w_wr_next;
            end
            if (w_rd_en) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_wr_en, w_rd_en})
                2'b10: begin
                    r_empty <= 1'b0;
                    r_full  <= (w_wr_next == r_rd_ptr);
                end
                2'b01: begin
                    r_full  <= 1'b0;
                    r_empty <= (w_rd_next == r_wr_ptr);
                end
                default: ;
            endcase
        end
    end

    assign key_code     = r_mem[r_rd_ptr];
    assign kb_buf_empty = r_empty;
    assign kb_buf_full  = r_full;
    assign frame_err    = r_frame_err;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keycode_rx
//  Brief    : Directed self-checking bench for ps2_keycode_rx.
//  Revision : 1.0
// ============================================================================
module tb_ps2_keycode_rx;

    localparam int HP  = 20;   // PS/2 half period in system clocks
    localparam int TMO = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2d;
    logic       ps2c;
    logic       rd_key_code;
    logic [7:0] key_code;
    logic       kb_buf_empty;
    logic       kb_buf_full;
    logic       frame_err;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;
    int n_ferr = 0;
    int n_ovf  = 0;

    ps2_keycode_rx #(
        .W_SIZE      (2),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TMO)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rd_key_code  (rd_key_code),
        .key_code     (key_code),
        .kb_buf_empty (kb_buf_empty),
        .kb_buf_full  (kb_buf_full),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a pulse stuck for more than one clock shows up.
    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overflow)  n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        repeat (HP) @(negedge clk);
        ps2c = 1'b0;
        repeat (HP) @(negedge clk);
        ps2c = 1'b1;
    endtask

    // mode 0: plain, 1: check empty edge around the push, 2: pop during LOAD
    task automatic ps2_frame(input logic [7:0] data, input logic bad_par, input int mode);
        logic [10:0] f;
        f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2d = f[10];
        repeat (HP) @(negedge clk);
        ps2c = 1'b0;
        if (mode == 1) begin
            repeat (11) @(negedge clk);
            check("empty_before_push", kb_buf_empty, 1);
            @(negedge clk);
            check("empty_after_push", kb_buf_empty, 0);
            repeat (HP - 12) @(negedge clk);
        end else if (mode == 2) begin
            repeat (11) @(negedge clk);
            rd_key_code = 1'b1;
            @(negedge clk);
            rd_key_code = 1'b0;
            repeat (HP - 12) @(negedge clk);
        end else begin
            repeat (HP) @(negedge clk);
        end
        ps2c = 1'b1;
        repeat (HP) @(negedge clk);
    endtask

    task automatic release_key(input logic [7:0] code);
        ps2_frame(8'hF0, 1'b0, 0);
        ps2_frame(code, 1'b0, 0);
    endtask

    task automatic pop_head(input string tag, input logic [7:0] exp);
        check(tag, key_code, exp);
        rd_key_code = 1'b1;
        @(negedge clk);
        rd_key_code = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_key"},   key_code, 8'h00);
        check({tag, "_empty"}, kb_buf_empty, 1);
        check({tag, "_full"},  kb_buf_full, 0);
        check({tag, "_ferr"},  frame_err, 0);
        check({tag, "_ovf"},   overflow, 0);
    endtask

    logic [7:0] codes [5];

    initial begin
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd_key_code = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (HP) @(negedge clk);

        // Single keystroke
        ps2_frame(8'h1C, 1'b0, 0);
        ps2_frame(8'hF0, 1'b0, 0);
        ps2_frame(8'h1C, 1'b0, 1);
        check("single_full", kb_buf_full, 0);
        pop_head("single_head", 8'h1C);
        check("single_empty_after_pop", kb_buf_empty, 1);
        check("single_no_ferr", n_ferr, 0);

        // Parity error drops the break prefix
        ps2_frame(8'hF0, 1'b1, 0);
        ps2_frame(8'h1C, 1'b0, 0);
        check("parity_ferr", n_ferr, 1);
        check("parity_empty", kb_buf_empty, 1);
        release_key(8'h1C);
        check("parity_recover_nonempty", kb_buf_empty, 0);
        pop_head("parity_recover_head", 8'h1C);
        check("parity_recover_empty", kb_buf_empty, 1);

        // Timeout on a truncated frame
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        repeat (TMO + 60) @(negedge clk);
        check("timeout_ferr", n_ferr, 2);
        check("timeout_empty", kb_buf_empty, 1);
        release_key(8'h2A);
        pop_head("timeout_recover_head", 8'h2A);
        check("timeout_no_extra_ferr", n_ferr, 2);

        // Reset in the middle of a frame
        release_key(8'h33);
        check("prereset_nonempty", kb_buf_empty, 0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (TMO + 60) @(negedge clk);
        check("midreset_no_timeout", n_ferr, 2);
        release_key(8'h1C);
        pop_head("postreset_head", 8'h1C);
        check("postreset_empty", kb_buf_empty, 1);

        // Overflow
        for (int i = 0; i < 4; i++) begin
            release_key(codes[i]);
            if (i == 2) check("ovf_not_full_at_3", kb_buf_full, 0);
        end
        check("ovf_full_at_4", kb_buf_full, 1);
        check("ovf_none_yet", n_ovf, 0);
        release_key(codes[4]);
        check("ovf_pulse", n_ovf, 1);
        check("ovf_still_full", kb_buf_full, 1);
        for (int i = 0; i < 4; i++) pop_head("ovf_pop_order", codes[i]);
        check("ovf_drained", kb_buf_empty, 1);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) release_key(codes[i]);
        check("sim_full_before", kb_buf_full, 1);
        ps2_frame(8'hF0, 1'b0, 0);
        ps2_frame(8'h3C, 1'b0, 2);
        check("sim_no_ovf", n_ovf, 1);
        check("sim_still_full", kb_buf_full, 1);
        pop_head("sim_head0", 8'h1D);
        pop_head("sim_head1", 8'h24);
        pop_head("sim_head2", 8'h2D);
        pop_head("sim_head3", 8'h3C);
        check("sim_drained", kb_buf_empty, 1);

        // Extended key release
        ps2_frame(8'hE0, 1'b0, 0);
        ps2_frame(8'hF0, 1'b0, 0);
        ps2_frame(8'hE0, 1'b0, 0);
        ps2_frame(8'h75, 1'b0, 0);
        check("ext_nonempty", kb_buf_empty, 0);
        pop_head("ext_head", 8'h75);
        check("ext_single_entry", kb_buf_empty, 1);
        check("ext_no_ferr", n_ferr, 2);
        check("final_ovf_count", n_ovf, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
